// File: rtl/pipe_pkg.sv
// Shared control-bundle layout for the ID/EX stage: field offsets, the bundle
// struct and small accessors so consumers never hard-code bit positions.
package pipe_pkg;

  localparam int CTRL_W      = 9;
  localparam int WB_REGWRITE = 8;
  localparam int M_BRANCH    = 6;
  localparam int M_MEMREAD   = 5;
  localparam int M_MEMWRITE  = 4;
  localparam int EX_REGDST   = 3;

  typedef struct packed {
    logic [1:0] wb;
    logic [2:0] m;
    logic [3:0] ex;
  } ctrl_t;

  function automatic logic reg_write(input ctrl_t c);
    return c[WB_REGWRITE];
  endfunction

  function automatic logic is_branch(input ctrl_t c);
    return c[M_BRANCH];
  endfunction

  function automatic logic mem_read(input ctrl_t c);
    return c[M_MEMREAD];
  endfunction

  function automatic logic mem_write(input ctrl_t c);
    return c[M_MEMWRITE];
  endfunction

  function automatic logic reg_dst(input ctrl_t c);
    return c[EX_REGDST];
  endfunction

endpackage

// File: rtl/load_scoreboard.sv
// In-flight load tracker: a LOAD_LAT-deep shift register of {valid, dest reg}
// and the load-use match against the ID source registers.
module load_scoreboard #(
  parameter int LOAD_LAT = 1,
  parameter int REG_AW   = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [REG_AW-1:0] push_reg,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_uses_rt,
  output logic              load_hz
);

  logic [LOAD_LAT-1:0] v_q;
  logic [REG_AW-1:0]   reg_q [LOAD_LAT];
  logic                hit;

  // Shifts every cycle; a cycle with no issuing load pushes an empty slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      v_q <= '0;
      for (int i = 0; i < LOAD_LAT; i++) reg_q[i] <= '0;
    end else begin
      for (int i = LOAD_LAT - 1; i > 0; i--) begin
        v_q[i]   <= v_q[i-1];
        reg_q[i] <= reg_q[i-1];
      end
      v_q[0]   <= push;
      reg_q[0] <= push_reg;
    end
  end

  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < LOAD_LAT; i++) begin
      if (v_q[i] && (reg_q[i] != '0) &&
          ((reg_q[i] == id_rs) || (id_uses_rt && (reg_q[i] == id_rt))))
        hit = 1'b1;
    end
    load_hz = id_valid && hit;
  end

endmodule

// File: rtl/id_ex_hazard_pipe.sv
// Decode-side hazard detection, ID-stage branch resolution and the ID/EX
// pipeline register. LOAD_LAT must lie in 1..4.
module id_ex_hazard_pipe
  import pipe_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 32,
  parameter int REG_AW   = 5,
  parameter int LOAD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_uses_rt,
  input  logic              id_branch_ne,
  input  logic [15:0]       id_imm,
  input  logic [DATA_W-1:0] id_rdata1,
  input  logic [DATA_W-1:0] id_rdata2,
  input  logic [ADDR_W-1:0] id_next_pc,
  output logic              pc_write,
  output logic              ifid_write,
  output logic              ifid_flush,
  output logic              pc_src,
  output logic [ADDR_W-1:0] branch_target,
  output logic              ex_valid,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [REG_AW-1:0] ex_rs,
  output logic [REG_AW-1:0] ex_rt,
  output logic [REG_AW-1:0] ex_rd,
  output logic [DATA_W-1:0] ex_imm,
  output logic [DATA_W-1:0] ex_data1,
  output logic [DATA_W-1:0] ex_data2,
  output logic [31:0]       stall_count
);

  ctrl_t             id_c;
  ctrl_t             ex_c_q;
  logic              ex_valid_q;
  logic [REG_AW-1:0] ex_rs_q, ex_rt_q, ex_rd_q;
  logic [DATA_W-1:0] ex_imm_q, ex_data1_q, ex_data2_q;
  logic [31:0]       stall_cnt_q;

  logic              load_hz, br_hz, stall, issue, taken;
  logic [REG_AW-1:0] ex_dst;
  logic [DATA_W-1:0] imm_sext;
  logic [ADDR_W-1:0] br_offset;

  assign id_c      = ctrl_t'(id_ctrl);
  assign imm_sext  = {{(DATA_W-16){id_imm[15]}}, id_imm};
  assign br_offset = {{(ADDR_W-18){id_imm[15]}}, id_imm, 2'b00};

  load_scoreboard #(
    .LOAD_LAT (LOAD_LAT),
    .REG_AW   (REG_AW)
  ) u_load_scoreboard (
    .clk        (clk),
    .rst        (rst),
    .push       (issue && mem_read(id_c)),
    .push_reg   (id_rt),
    .id_valid   (id_valid),
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .id_uses_rt (id_uses_rt),
    .load_hz    (load_hz)
  );

  // A branch compares in ID, so a producer still in EX has no result yet.
  always_comb begin
    ex_dst = reg_dst(ex_c_q) ? ex_rd_q : ex_rt_q;
    br_hz  = id_valid && is_branch(id_c) && ex_valid_q && reg_write(ex_c_q) &&
             (ex_dst != '0) && ((ex_dst == id_rs) || (ex_dst == id_rt));
    stall  = !rst && (load_hz || br_hz);
    issue  = !rst && id_valid && !stall;
    taken  = issue && is_branch(id_c) &&
             ((id_rdata1 == id_rdata2) ^ id_branch_ne);

    pc_write   = !stall;
    ifid_write = !stall;
    ifid_flush = taken;
    pc_src     = taken;
  end

  assign branch_target = id_next_pc + br_offset;

  // On a stall only valid/ctrl are cleared; the data fields hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid_q  <= 1'b0;
      ex_c_q      <= '0;
      ex_rs_q     <= '0;
      ex_rt_q     <= '0;
      ex_rd_q     <= '0;
      ex_imm_q    <= '0;
      ex_data1_q  <= '0;
      ex_data2_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (stall && (stall_cnt_q != '1))
        stall_cnt_q <= stall_cnt_q + 32'd1;
      if (stall) begin
        ex_valid_q <= 1'b0;
        ex_c_q     <= '0;
      end else begin
        ex_valid_q <= id_valid;
        ex_c_q     <= id_valid ? id_c : '0;
        ex_rs_q    <= id_rs;
        ex_rt_q    <= id_rt;
        ex_rd_q    <= id_rd;
        ex_imm_q   <= imm_sext;
        ex_data1_q <= id_rdata1;
        ex_data2_q <= id_rdata2;
      end
    end
  end

  assign ex_valid    = ex_valid_q;
  assign ex_ctrl     = ex_c_q;
  assign ex_rs       = ex_rs_q;
  assign ex_rt       = ex_rt_q;
  assign ex_rd       = ex_rd_q;
  assign ex_imm      = ex_imm_q;
  assign ex_data1    = ex_data1_q;
  assign ex_data2    = ex_data2_q;
  assign stall_count = stall_cnt_q;

endmodule

// File: tb/tb_id_ex_hazard_pipe.sv
// Bench for id_ex_hazard_pipe: LOAD_LAT=1 and LOAD_LAT=3 instances share inputs
// and are compared each cycle against a cycle-stamp reference model.
module tb_id_ex_hazard_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [8:0]  id_ctrl;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic        id_uses_rt, id_branch_ne;
  logic [15:0] id_imm;
  logic [31:0] id_rdata1, id_rdata2, id_next_pc;

  logic        pc_write_o [2];
  logic        ifid_write_o [2];
  logic        ifid_flush_o [2];
  logic        pc_src_o [2];
  logic [31:0] branch_target_o [2];
  logic        ex_valid_o [2];
  logic [8:0]  ex_ctrl_o [2];
  logic [4:0]  ex_rs_o [2], ex_rt_o [2], ex_rd_o [2];
  logic [31:0] ex_imm_o [2], ex_data1_o [2], ex_data2_o [2];
  logic [31:0] stall_count_o [2];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    id_ex_hazard_pipe #(.LOAD_LAT(g == 0 ? 1 : 3)) u_dut (
      .clk           (clk),
      .rst           (rst),
      .id_valid      (id_valid),
      .id_ctrl       (id_ctrl),
      .id_rs         (id_rs),
      .id_rt         (id_rt),
      .id_rd         (id_rd),
      .id_uses_rt    (id_uses_rt),
      .id_branch_ne  (id_branch_ne),
      .id_imm        (id_imm),
      .id_rdata1     (id_rdata1),
      .id_rdata2     (id_rdata2),
      .id_next_pc    (id_next_pc),
      .pc_write      (pc_write_o[g]),
      .ifid_write    (ifid_write_o[g]),
      .ifid_flush    (ifid_flush_o[g]),
      .pc_src        (pc_src_o[g]),
      .branch_target (branch_target_o[g]),
      .ex_valid      (ex_valid_o[g]),
      .ex_ctrl       (ex_ctrl_o[g]),
      .ex_rs         (ex_rs_o[g]),
      .ex_rt         (ex_rt_o[g]),
      .ex_rd         (ex_rd_o[g]),
      .ex_imm        (ex_imm_o[g]),
      .ex_data1      (ex_data1_o[g]),
      .ex_data2      (ex_data2_o[g]),
      .stall_count   (stall_count_o[g])
    );
  end

  localparam logic [8:0] LW  = 9'b11_010_0001;
  localparam logic [8:0] ADD = 9'b10_000_1000;
  localparam logic [8:0] BR  = 9'b00_100_0000;

  int errors = 0;
  int checks = 0;

  // Reference model: a load issued at cycle k blocks its register in cycles
  // k+1 .. k+lat; ID/EX is modelled as the last issued instruction.
  int          lat [2] = '{1, 3};
  int          cyc = 0;
  int          ld_cyc [2][32];
  logic        m_valid [2];
  logic [8:0]  m_ctrl [2];
  logic [4:0]  m_rs [2], m_rt [2], m_rd [2];
  logic [31:0] m_imm [2], m_d1 [2], m_d2 [2], m_cnt [2];
  logic        m_known [2];
  logic        e_stall [2], e_taken [2];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic set_in(input logic v, input logic [8:0] c, input logic [4:0] rs, rt, rd,
                        input logic ut, ne, input logic [15:0] imm,
                        input logic [31:0] d1, d2, pc);
    id_valid = v; id_ctrl = c; id_rs = rs; id_rt = rt; id_rd = rd;
    id_uses_rt = ut; id_branch_ne = ne; id_imm = imm;
    id_rdata1 = d1; id_rdata2 = d2; id_next_pc = pc;
  endtask

  function automatic logic blocked(input int l, input logic [4:0] r);
    int d;
    d = cyc - ld_cyc[l][r];
    return (r != 0) && (d >= 1) && (d <= lat[l]);
  endfunction

  task automatic sample();
    logic [4:0]  dst;
    logic        lh, bh;
    logic [31:0] tgt;
    @(negedge clk);
    tgt = id_next_pc + ({{16{id_imm[15]}}, id_imm} << 2);
    for (int l = 0; l < 2; l++) begin
      lh  = blocked(l, id_rs) || (id_uses_rt && blocked(l, id_rt));
      dst = m_ctrl[l][3] ? m_rd[l] : m_rt[l];
      bh  = id_ctrl[6] && m_valid[l] && m_ctrl[l][8] && (dst != 0) &&
            ((dst == id_rs) || (dst == id_rt));
      e_stall[l] = !rst && id_valid && (lh || bh);
      e_taken[l] = !rst && !e_stall[l] && id_valid && id_ctrl[6] &&
                   ((id_rdata1 == id_rdata2) ^ id_branch_ne);
      check($sformatf("pc_write[%0d]", l), 64'(pc_write_o[l]), 64'(!e_stall[l]));
      check($sformatf("ifid_write[%0d]", l), 64'(ifid_write_o[l]), 64'(!e_stall[l]));
      check($sformatf("ifid_flush[%0d]", l), 64'(ifid_flush_o[l]), 64'(e_taken[l]));
      check($sformatf("pc_src[%0d]", l), 64'(pc_src_o[l]), 64'(e_taken[l]));
      check($sformatf("branch_target[%0d]", l), 64'(branch_target_o[l]), 64'(tgt));
      check($sformatf("ex_valid[%0d]", l), 64'(ex_valid_o[l]), 64'(m_valid[l]));
      check($sformatf("ex_ctrl[%0d]", l), 64'(ex_ctrl_o[l]), 64'(m_ctrl[l]));
      check($sformatf("stall_count[%0d]", l), 64'(stall_count_o[l]), 64'(m_cnt[l]));
      if (m_known[l]) begin
        check($sformatf("ex_rs[%0d]", l), 64'(ex_rs_o[l]), 64'(m_rs[l]));
        check($sformatf("ex_rt[%0d]", l), 64'(ex_rt_o[l]), 64'(m_rt[l]));
        check($sformatf("ex_rd[%0d]", l), 64'(ex_rd_o[l]), 64'(m_rd[l]));
        check($sformatf("ex_imm[%0d]", l), 64'(ex_imm_o[l]), 64'(m_imm[l]));
        check($sformatf("ex_data1[%0d]", l), 64'(ex_data1_o[l]), 64'(m_d1[l]));
        check($sformatf("ex_data2[%0d]", l), 64'(ex_data2_o[l]), 64'(m_d2[l]));
      end
    end
  endtask

  task automatic advance();
    @(posedge clk);
    for (int l = 0; l < 2; l++) begin
      if (rst) begin
        for (int r = 0; r < 32; r++) ld_cyc[l][r] = -1000;
        m_valid[l] = 0; m_ctrl[l] = 0; m_rs[l] = 0; m_rt[l] = 0; m_rd[l] = 0;
        m_imm[l] = 0; m_d1[l] = 0; m_d2[l] = 0; m_cnt[l] = 0; m_known[l] = 1;
      end else if (e_stall[l]) begin
        m_valid[l] = 0; m_ctrl[l] = 0;
        if (m_cnt[l] != 32'hFFFF_FFFF) m_cnt[l] = m_cnt[l] + 1;
      end else if (!id_valid) begin
        m_valid[l] = 0; m_ctrl[l] = 0; m_known[l] = 0;
      end else begin
        m_valid[l] = 1; m_ctrl[l] = id_ctrl; m_known[l] = 1;
        m_rs[l] = id_rs; m_rt[l] = id_rt; m_rd[l] = id_rd;
        m_imm[l] = {{16{id_imm[15]}}, id_imm};
        m_d1[l] = id_rdata1; m_d2[l] = id_rdata2;
        if (id_ctrl[5]) ld_cyc[l][id_rt] = cyc;
      end
    end
    cyc++;
    #1;
  endtask

  task automatic do_reset();
    rst = 1;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    advance();
    sample();
    advance();
    rst = 0;
  endtask

  int st [2];

  initial begin
    for (int l = 0; l < 2; l++) begin
      e_stall[l] = 0; e_taken[l] = 0;
    end
    do_reset();

    // lw r8 then dependent add: 1 stall at LOAD_LAT=1, 3 at LOAD_LAT=3
    set_in(1, LW, 1, 8, 0, 0, 0, 16'h0004, 32'h10, 32'h0, 32'h40);
    sample(); advance();
    set_in(1, ADD, 8, 2, 9, 1, 0, 16'h0000, 32'h5, 32'h6, 32'h44);
    st[0] = 0; st[1] = 0;
    for (int i = 0; i < 5; i++) begin
      sample();
      for (int l = 0; l < 2; l++) if (!pc_write_o[l]) st[l]++;
      advance();
    end
    sample();
    check("lu_stalls_lat1", 64'(st[0]), 64'd1);
    check("lu_stalls_lat3", 64'(st[1]), 64'd3);
    check("lu_count_lat1", 64'(stall_count_o[0]), 64'd1);
    check("lu_count_lat3", 64'(stall_count_o[1]), 64'd3);
    advance();

    // lw r8, independent op, dependent op
    do_reset();
    set_in(1, LW, 1, 8, 0, 0, 0, 16'h0000, 32'h0, 32'h0, 32'h80);
    sample(); advance();
    set_in(1, ADD, 3, 4, 10, 1, 0, 16'h0000, 32'h1, 32'h2, 32'h84);
    sample(); advance();
    set_in(1, ADD, 8, 2, 9, 1, 0, 16'h0000, 32'h3, 32'h4, 32'h88);
    st[0] = 0; st[1] = 0;
    for (int i = 0; i < 4; i++) begin
      sample();
      for (int l = 0; l < 2; l++) if (!pc_write_o[l]) st[l]++;
      advance();
    end
    check("gap_stalls_lat1", 64'(st[0]), 64'd0);
    check("gap_stalls_lat3", 64'(st[1]), 64'd2);

    // r0 and unused-rt never hazard
    do_reset();
    set_in(1, LW, 1, 0, 0, 0, 0, 16'h0000, 32'h0, 32'h0, 32'h0);
    sample(); advance();
    set_in(1, ADD, 0, 0, 7, 1, 0, 16'h0000, 32'h0, 32'h0, 32'h4);
    sample();
    check("r0_nostall_lat3", 64'(pc_write_o[1]), 64'd1);
    advance();
    set_in(1, LW, 1, 5, 0, 0, 0, 16'h0000, 32'h0, 32'h0, 32'h8);
    sample(); advance();
    set_in(1, ADD, 1, 5, 6, 0, 0, 16'h0000, 32'h0, 32'h0, 32'hC);
    sample();
    check("nort_nostall_lat1", 64'(pc_write_o[0]), 64'd1);
    check("nort_nostall_lat3", 64'(pc_write_o[1]), 64'd1);
    advance();

    // BEQ taken / BNE not taken
    do_reset();
    set_in(1, BR, 1, 2, 0, 1, 0, 16'hFFFE, 32'h1234, 32'h1234, 32'h100);
    sample();
    check("beq_pc_src", 64'(pc_src_o[0]), 64'd1);
    check("beq_flush", 64'(ifid_flush_o[0]), 64'd1);
    check("beq_target", 64'(branch_target_o[0]), 64'hF8);
    advance();
    set_in(1, BR, 1, 2, 0, 1, 1, 16'hFFFE, 32'h1234, 32'h1234, 32'h100);
    sample();
    check("bne_pc_src", 64'(pc_src_o[0]), 64'd0);
    check("bne_target", 64'(branch_target_o[0]), 64'hF8);
    advance();

    // add r3 in EX, then BEQ on r3
    do_reset();
    set_in(1, ADD, 1, 2, 3, 1, 0, 16'h0000, 32'h1, 32'h2, 32'h200);
    sample(); advance();
    set_in(1, BR, 3, 4, 0, 1, 0, 16'h0004, 32'h5, 32'h5, 32'h204);
    sample();
    check("brhz_stall", 64'(pc_write_o[0]), 64'd0);
    check("brhz_no_src", 64'(pc_src_o[0]), 64'd0);
    advance();
    sample();
    check("brhz_resolve", 64'(pc_src_o[0]), 64'd1);
    check("brhz_target", 64'(branch_target_o[0]), 64'h214);
    advance();

    // reset during a LOAD_LAT=3 stall
    do_reset();
    set_in(1, LW, 1, 8, 0, 0, 0, 16'h0000, 32'h0, 32'h0, 32'h300);
    sample(); advance();
    set_in(1, ADD, 8, 2, 9, 1, 0, 16'h0000, 32'h7, 32'h8, 32'h304);
    sample();
    check("pre_rst_stall", 64'(pc_write_o[1]), 64'd0);
    advance();
    rst = 1;
    sample();
    check("in_rst_pc_write", 64'(pc_write_o[1]), 64'd1);
    advance();
    rst = 0;
    sample();
    check("post_rst_ex_valid", 64'(ex_valid_o[1]), 64'd0);
    check("post_rst_ex_data1", 64'(ex_data1_o[1]), 64'd0);
    check("post_rst_count", 64'(stall_count_o[1]), 64'd0);
    check("post_rst_nostall", 64'(pc_write_o[1]), 64'd1);
    advance();

    // randomized traffic on small register indices
    for (int i = 0; i < 400; i++) begin
      logic [8:0]  c;
      logic [31:0] d1;
      c = 9'($urandom);
      c[5] = ($urandom_range(0, 9) < 3);
      d1 = $urandom;
      rst = ($urandom_range(0, 49) == 0);
      set_in(($urandom_range(0, 9) < 8), c, 5'($urandom_range(0, 7)),
             5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
             1'($urandom), 1'($urandom), 16'($urandom), d1,
             ($urandom_range(0, 1) == 0) ? d1 : $urandom, $urandom);
      sample();
      advance();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/id_ex_hazard_pipe.md
Name: id_ex_hazard_pipe

Overview:
- Parametrised successor to the decode-side hazard logic and ID/EX register of the 5-stage pipeline.
- Takes decoded ID fields and register-file read data, and detects load-use hazards against a LOAD_LAT-deep in-flight load scoreboard.
- Resolves BEQ/BNE in ID, including branch-on-EX-producer stalls.
- Drives PC/IF-ID write enables and the IF/ID flush, and registers everything into the ID/EX stage. Bubbles are inserted on stall.

Parameters:
- DATA_W, 32, register data width
- ADDR_W, 32, PC/branch-target width
- REG_AW, 5, register index width
- LOAD_LAT, 1, load-use stall distance in cycles (legal 1..4)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- id_valid  in  1  ID slot holds a real instruction
- id_ctrl  in  9  control bundle {wb[1:0],m[2:0],ex[3:0]}
- id_rs, id_rt, id_rd  in  REG_AW each  source/destination indices
- id_uses_rt  in  1  instruction reads rt as a source
- id_branch_ne  in  1  branch is BNE (else BEQ); meaningful only when m[2]=1
- id_imm  in  16  raw immediate
- id_rdata1, id_rdata2  in  DATA_W each  register-file read data
- id_next_pc  in  ADDR_W  PC+4 of the ID instruction
- pc_write  out  1  PC update enable
- ifid_write  out  1  IF/ID update enable
- ifid_flush  out  1  squash IF/ID (taken branch)
- pc_src  out  1  select branch_target
- branch_target  out  ADDR_W  id_next_pc + (sext(id_imm)<<2), truncated to ADDR_W
- ex_valid  out  1  registered valid
- ex_ctrl  out  9  registered control bundle
- ex_rs, ex_rt, ex_rd  out  REG_AW each  registered indices
- ex_imm  out  DATA_W  registered sign-extended immediate
- ex_data1, ex_data2  out  DATA_W each  registered read data
- stall_count  out  32  saturating count of stall cycles

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset: all ex_* outputs = 0, scoreboard cleared, stall_count = 0.
- While rst=1: pc_write=1, ifid_write=1, ifid_flush=0, pc_src=0.
- Control bundle bits: m[1] = MemRead, m[0] = MemWrite, m[2] = Branch, wb[1] = RegWrite.
- Scoreboard: LOAD_LAT entries, each {v, reg}, shifted one place every cycle.
  - Entry 0 is loaded with {1, id_rt} when an issuing instruction has MemRead=1; otherwise entry 0 is loaded with v=0.
  - The oldest entry drops off.
- load_hz (combinational): id_valid, and any valid entry whose reg ≠ 0 and equals id_rs, or equals id_rt when id_uses_rt=1.
- br_hz (combinational): id_valid, m[2]=1, ex_valid, ex_ctrl.wb[1]=1, ex destination ≠ 0, and ex destination equals id_rs or id_rt.
  - ex destination is ex_rd if ex_ctrl.ex[3] (RegDst), else ex_rt.
- stall = load_hz | br_hz. While stalled:
  - pc_write = 0, ifid_write = 0.
  - ID/EX captures a bubble: ex_valid = 0, ex_ctrl = 0, other ex_* fields don't-care but are held.
  - Nothing is pushed into the scoreboard.
  - stall_count increments, saturating at 0xFFFF_FFFF.
- Branch resolves only when not stalled: taken = m[2] & id_valid & ((id_rdata1 == id_rdata2) XOR id_branch_ne).
  - taken drives pc_src = 1 and ifid_flush = 1 combinationally in the same cycle.
  - The branch itself enters ID/EX normally.
- Stall and taken branch in the same cycle: stall wins; pc_src = 0, ifid_flush = 0.
- id_valid = 0: no stall, no branch; ID/EX gets a bubble.
- Latency: one cycle from ID inputs to ex_* outputs.
- Load-use with LOAD_LAT = N: a dependent instruction directly behind a load stalls N cycles, then issues.
- Register 0 never creates a hazard.
- Reset asserted mid-stall: the next cycle has an empty scoreboard and no stall.

Decomposition:
- Shared package (pipe_pkg) holds:
  - CTRL_W = 9.
  - Bundle field offsets (WB_REGWRITE = 8, M_BRANCH = 6, M_MEMREAD = 5, M_MEMWRITE = 4, EX_REGDST = 3).
  - A ctrl_t packed struct.
- One sub-module, load_scoreboard: the shift register plus match logic, parametrised by LOAD_LAT and REG_AW, outputting load_hz.

Test Plan:
- LOAD_LAT=1: `lw r8,0(r1)` then `add r9,r8,r2` -> exactly 1 stall cycle (pc_write=0 for 1 cycle), one ex_valid=0 bubble, add issues next; stall_count=1.
- LOAD_LAT=3: `lw r8` then dependent `add` -> 3 stall cycles. `lw r8`, independent op, then dependent op -> 2 stall cycles.
- `lw r0` followed by a consumer of r0 -> no stall. Load to r5 followed by an instruction with id_uses_rt=0 and id_rt=5 -> no stall.
- BEQ taken: rdata1 = rdata2 = 0x1234, id_next_pc = 0x100, imm = 0xFFFE -> pc_src=1, ifid_flush=1, branch_target=0xF8. BNE with equal data -> not taken, branch_target still computed.
- `add r3,...` in EX (RegDst=1, rd=3) then BEQ reading r3 -> 1 stall cycle, no pc_src during the stall, branch resolves the following cycle.
- Assert rst during a LOAD_LAT=3 stall -> next cycle: ex_* = 0, stall_count=0, pc_write=1, and the dependent instruction is not stalled.
